// File: rtl/htif_pkg.sv
// Shared types and default widths for the HTIF PCR host port.
package htif_pkg;

  localparam int PCR_ADDR_W = 12;
  localparam int PCR_DATA_W = 64;

  typedef enum logic [1:0] {
    HRST = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2,
    REP  = 2'd3
  } htif_state_e;

  typedef struct packed {
    logic                  rw;
    logic [PCR_ADDR_W-1:0] addr;
    logic [PCR_DATA_W-1:0] data;
  } pcr_req_t;

endpackage

// File: rtl/htif_pcr_host.sv
// Host-side initiator for the core HTIF PCR port: host reset sequencing plus one command at a time.
// Optional per-command timeout enabled by defining HTIF_PCR_HOST_TIMEOUT_EN.
module htif_pcr_host
  import htif_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 256,
  parameter int ADDR_W     = PCR_ADDR_W,
  parameter int DATA_W     = PCR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy,
  output logic              host_reset,
  output logic              pcr_req_valid,
  input  logic              pcr_req_ready,
  output logic              pcr_req_rw,
  output logic [ADDR_W-1:0] pcr_req_addr,
  output logic [DATA_W-1:0] pcr_req_data,
  output logic              pcr_rep_ready,
  input  logic              pcr_rep_valid,
  input  logic [DATA_W-1:0] pcr_rep_bits
);

  localparam logic [1:0] S_HRST = HRST;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_REP  = REP;

  localparam int            HW     = $clog2(RST_CYCLES + 1);
  localparam logic [HW-1:0] H_LAST = HW'(RST_CYCLES - 1);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("htif_pcr_host: RST_CYCLES must be >= 1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("htif_pcr_host: TIMEOUT must be >= 2");
  end

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [1:0]    state;
  logic [HW-1:0] hcnt;
  req_t          req_q;
  logic          abort;

  // Every handshake-facing output is a pure decode of the state register.
  assign host_reset    = (state == S_HRST);
  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign pcr_req_valid = (state == S_REQ);
  assign pcr_rep_ready = (state == S_REP);
  assign pcr_req_rw    = req_q.rw;
  assign pcr_req_addr  = req_q.addr;
  assign pcr_req_data  = req_q.data;

`ifdef HTIF_PCR_HOST_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt;
  logic          expired;
  logic          err_q;

  // Budget spans REQ and REP; it saturates so a late request handshake leaves REP no slack.
  assign expired = (tcnt >= T_LAST);
  assign abort   = expired && (((state == S_REQ) && !pcr_req_ready) ||
                               ((state == S_REP) && !pcr_rep_valid));
  assign res_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst || state == S_IDLE || state == S_HRST) tcnt <= '0;
    else if (!expired)                              tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)                                      err_q <= 1'b0;
    else if (abort)                                err_q <= 1'b1;
    else if (state == S_REP && pcr_rep_valid)      err_q <= 1'b0;
  end
`else
  assign abort   = 1'b0;
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_HRST;
      hcnt      <= '0;
      req_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_HRST: begin
          if (hcnt == H_LAST) state <= S_IDLE;
          else                hcnt  <= hcnt + 1'b1;
        end
        S_IDLE: begin
          if (cmd_valid) begin
            req_q <= {cmd_rw, cmd_addr, cmd_data};
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (pcr_req_ready) state <= S_REP;
          else if (abort) begin
            state     <= S_IDLE;
            res_valid <= 1'b1;
            res_data  <= '0;
          end
        end
        S_REP: begin
          if (pcr_rep_valid) begin
            state     <= S_IDLE;
            res_valid <= 1'b1;
            res_data  <= pcr_rep_bits;
          end else if (abort) begin
            state     <= S_IDLE;
            res_valid <= 1'b1;
            res_data  <= '0;
          end
        end
        default: state <= S_HRST;
      endcase
    end
  end

endmodule

// File: tb/tb_htif_pcr_host.sv
// Directed/random bench for htif_pcr_host with a PCR-register memory model for expected replies.
module tb_htif_pcr_host;
  import htif_pkg::*;

  localparam int RST_CYC = 4;
  localparam int TO      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        res_valid, res_err, busy, host_reset;
  logic [63:0] res_data;
  logic        pcr_req_valid, pcr_req_ready = 1'b0, pcr_req_rw;
  logic [11:0] pcr_req_addr;
  logic [63:0] pcr_req_data;
  logic        pcr_rep_ready, pcr_rep_valid = 1'b0;
  logic [63:0] pcr_rep_bits = '0;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic [63:0] mem [0:4095];
  logic [63:0] last_res = '0;
  logic        last_err = 1'b0;

  htif_pcr_host #(.RST_CYCLES(RST_CYC), .TIMEOUT(TO), .ADDR_W(12), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .busy(busy), .host_reset(host_reset),
    .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready),
    .pcr_req_rw(pcr_req_rw), .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
    .pcr_rep_ready(pcr_rep_ready), .pcr_rep_valid(pcr_rep_valid), .pcr_rep_bits(pcr_rep_bits)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && pcr_req_valid && pcr_req_ready) hs_cnt <= hs_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    int k;
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      cmd_valid = 1'b0; pcr_req_ready = 1'b0; pcr_rep_valid = 1'b0;
      chk("rst_host_reset", host_reset, 1);
      chk("rst_busy", busy, 1);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_req_valid", pcr_req_valid, 0);
      chk("rst_rep_ready", pcr_rep_ready, 0);
      chk("rst_req_fields", {pcr_req_rw, pcr_req_addr, pcr_req_data[50:0]}, 0);
    end
    rst = 1'b1;
    k = 0;
    while (host_reset === 1'b1 && k < 64) begin
      chk("hrst_res_valid", res_valid, 0);
      k++;
      tick();
    end
    chk("hrst_len", k, RST_CYC);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    last_res = '0;
    last_err = 1'b0;
  endtask

  // One command through a core that delays req_ready by rd and the reply by pd cycles.
  task automatic do_cmd(input logic rw, input logic [11:0] addr, input logic [63:0] data,
                        input int rd, input int pd, input bit junk);
    pcr_req_t    r;
    logic [63:0] exp;
    int          hs0;
    r   = '{rw: rw, addr: addr, data: data};
    exp = mem[addr];
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_data = data;
    pcr_rep_valid = junk; pcr_rep_bits = {$urandom, $urandom};
    hs0 = hs_cnt;
    tick();
    // Keep offering a different command while busy; it must not be taken.
    cmd_rw = ~rw; cmd_addr = addr ^ 12'h0F0; cmd_data = ~data;
    for (int i = 0; i <= rd; i++) begin
      chk("req_valid", pcr_req_valid, 1);
      chk("req_fields", {pcr_req_rw, pcr_req_addr, pcr_req_data[50:0]},
          {r.rw, r.addr, r.data[50:0]});
      chk("req_data", pcr_req_data, r.data);
      chk("busy_cmd_ready", cmd_ready, 0);
      chk("busy_res_valid", res_valid, 0);
      chk("res_hold", {res_err, res_data[62:0]}, {last_err, last_res[62:0]});
      pcr_req_ready = (i == rd);
      pcr_rep_valid = junk && (i == rd);
      pcr_rep_bits  = ~exp;
      tick();
    end
    pcr_req_ready = 1'b0; pcr_rep_valid = 1'b0;
    chk("req_handshakes", hs_cnt - hs0, 1);
    for (int i = 0; i <= pd; i++) begin
      chk("rep_ready", pcr_rep_ready, 1);
      chk("rep_req_valid", pcr_req_valid, 0);
      chk("rep_res_valid", res_valid, 0);
      if (i == pd) begin
        cmd_valid = 1'b0; pcr_rep_valid = 1'b1; pcr_rep_bits = exp;
      end
      tick();
    end
    pcr_rep_valid = 1'b0;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp);
    chk("res_err", res_err, 0);
    chk("res_cmd_ready", cmd_ready, 1);
    chk("res_rep_ready", pcr_rep_ready, 0);
    if (rw) mem[addr] = data;
    last_res = exp;
    last_err = 1'b0;
  endtask

`ifdef HTIF_PCR_HOST_TIMEOUT_EN
  task automatic do_timeout(input bit req_hs);
    chk("to_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h0AB; cmd_data = '0;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      chk("to_res_valid", res_valid, 0);
      chk("to_busy", busy, 1);
      pcr_req_ready = req_hs && (k == 1);
      tick();
    end
    pcr_req_ready = 1'b0;
    chk("to_res_valid_pulse", res_valid, 1);
    chk("to_res_err", res_err, 1);
    chk("to_res_data", res_data, 0);
    chk("to_req_valid", pcr_req_valid, 0);
    chk("to_rep_ready", pcr_rep_ready, 0);
    last_res = '0;
    last_err = 1'b1;
  endtask
`endif

  initial begin
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};

    do_reset(3);

    mem[12'h01C] = 64'h0000_0000_DEAD_BEEF;
    do_cmd(1'b0, 12'h01C, 64'h0, 0, 0, 1'b1);
    do_cmd(1'b1, 12'h005, 64'h1234, 5, $urandom_range(0, 3), 1'b0);
    do_cmd(1'b0, 12'h005, 64'h0, 0, 0, 1'b0);
    chk("write_readback", last_res, 64'h1234);

    for (int i = 0; i < 4; i++)
      do_cmd(1'b0, 12'($urandom_range(0, 4095)), 64'h0,
             $urandom_range(0, 7), $urandom_range(0, 7), 1'b0);

    for (int i = 0; i < 20; i++) begin
      a = 12'($urandom_range(0, 7) * 9);
      do_cmd(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
             $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

`ifdef HTIF_PCR_HOST_TIMEOUT_EN
    do_timeout(1'b1);
    do_cmd(1'b0, 12'h010, 64'h0, 1, 2, 1'b0);
    do_timeout(1'b0);
    do_cmd(1'b0, 12'h011, 64'h0, 0, TO - 2, 1'b0);
    do_cmd(1'b1, 12'h012, 64'hABCD, 7, TO - 9, 1'b0);
`endif

    // Reset while waiting for a reply: command is dropped, no result.
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h033;
    tick();
    cmd_valid = 1'b0; pcr_req_ready = 1'b1;
    tick();
    pcr_req_ready = 1'b0;
    chk("mid_rep_ready", pcr_rep_ready, 1);
    tick();
    pcr_rep_valid = 1'b1; pcr_rep_bits = 64'h5555;
    do_reset(1);
    do_cmd(1'b0, 12'h033, 64'h0, 2, 1, 1'b0);

    tick();
    chk("final_pulse_end", res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/htif_pcr_host.md
Name: htif_pcr_host

Overview:
- Host-side initiator for the core's HTIF PCR port. The core is the responder on this port; this block drives it.
- Sequences the core's host reset after system reset.
- Accepts one PCR read/write command at a time from a bench or controller.
- Drives the pcr_req valid/ready channel, collects the pcr_rep reply and returns the result.

Parameters:
- RST_CYCLES, 4: number of cycles io_host_reset is held high after rst deasserts; must be ≥1.
- TIMEOUT, 256: cycle budget per command, counted across the REQ and REP states; must be ≥2.
- ADDR_W, 12: PCR address width.
- DATA_W, 64: PCR data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_rw  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  PCR address
- cmd_data  in  DATA_W  write data
- res_valid  out  1  one-cycle result pulse
- res_data  out  DATA_W  reply data
- res_err  out  1  command aborted (timeout)
- busy  out  1  state is not IDLE
- host_reset  out  1  to core io_host_reset
- pcr_req_valid  out  1  to core
- pcr_req_ready  in  1  from core
- pcr_req_rw  out  1  to core
- pcr_req_addr  out  ADDR_W  to core
- pcr_req_data  out  DATA_W  to core
- pcr_rep_ready  out  1  to core
- pcr_rep_valid  in  1  from core
- pcr_rep_bits  in  DATA_W  from core

Behaviour:
- Reset (rst=0 at a clk edge): state=HRST, counter=0, host_reset=1.
  - All other outputs are 0: cmd_ready, res_valid, res_data, res_err, pcr_req_*, pcr_rep_ready.
  - busy=1.
- All outputs are registered or decoded from state registers only; no combinational path from any input to any output.
- FSM states: HRST, IDLE, REQ, REP.
- HRST:
  - host_reset=1; counter increments each cycle.
  - After RST_CYCLES cycles with rst=1, go to IDLE with host_reset=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch rw/addr/data into the request registers, clear the timeout counter, go to REQ.
- REQ:
  - pcr_req_valid=1; rw/addr/data stay stable until the handshake.
  - On pcr_req_ready, go to REP.
  - valid is never withdrawn before ready, except on a timeout abort.
- REP:
  - pcr_rep_ready=1.
  - On pcr_rep_valid, capture pcr_rep_bits and go to IDLE.
  - Next cycle: res_valid=1, res_data=captured value, res_err=0.
- Both reads and writes expect exactly one reply. For a write, the reply data (the old PCR value) is returned in res_data.
- Latency with zero-wait core:
  - cmd handshake at cycle t → pcr_req_valid at t+1.
  - Reply accepted at t+2 → res_valid at t+3.
  - Next cmd can be accepted at t+3, with res_valid in the same cycle.
- res_valid is a single-cycle pulse with no backpressure. res_data/res_err hold their values until the next result.
- pcr_rep_valid arriving outside REP is ignored; pcr_rep_ready is 0 there.
- pcr_req_ready and pcr_rep_valid arriving in the same cycle in REQ: only the request handshake completes; the reply is taken in REP at earliest the next cycle.
- rst=0 in any state: immediate return to HRST with the reset values above. Any in-flight command is dropped and no result is produced.

Optional Feature:
- Macro: HTIF_PCR_HOST_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and REP.
  - If TIMEOUT cycles elapse without the pending handshake, drop pcr_req_valid/pcr_rep_ready and go to IDLE.
  - Next cycle: res_valid=1, res_err=1, res_data=0.
  - A handshake in the final budget cycle wins over the timeout.
- Undefined: no counter; the block waits indefinitely; res_err is tied 0.

Decomposition:
- Package htif_pkg:
  - State enum typedef (HRST/IDLE/REQ/REP).
  - Packed struct pcr_req_t {rw, addr, data}.
  - Default widths PCR_ADDR_W=12, PCR_DATA_W=64.
- Block is a single module; no sub-module.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then 1 → host_reset=1 for exactly 4 cycles, then cmd_ready=1 with busy=0.
- Read, zero-wait core: read addr 12'h01C, core replies 64'h0000_0000_DEAD_BEEF → res_valid exactly 3 cycles after the cmd handshake, res_data=DEADBEEF, res_err=0.
- Write with backpressure: write addr 12'h005 data 64'h1234, core holds pcr_req_ready=0 for 5 cycles → addr/data/rw stay stable throughout, exactly one request handshake, res_data equals the core's reply.
- Back-to-back: 4 reads with random core delays 0–7 → 4 res_valid pulses in order, with no cmd accepted while busy.
- Timeout (macro defined, TIMEOUT=16): core never asserts pcr_rep_valid → res_valid with res_err=1, res_data=0 16 cycles after entering REQ; the next command proceeds normally.
- Mid-command reset: rst=0 while in REP → no res_valid, host_reset is reasserted for RST_CYCLES, then IDLE.
